// File: rtl/usb_pkt_pkg.sv
// Shared types and constants for the USB bulk IN packetizer.
// Imported by the FIFO and the release FSM.
package usb_pkt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int HS_MAX_PACKET   = 512;
  localparam int FS_MAX_PACKET   = 64;
  localparam int DEFAULT_TIMEOUT = 4096;
  localparam int BEAT_W          = 9;

endpackage

// File: rtl/axis_usb_packetizer_if.sv
// Byte-wide AXI-Stream link with tlast.
// master drives the beat, slave returns tready.
interface axis_usb_packetizer_if;

  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic [7:0] tdata;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    output tready
  );

endinterface

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through FIFO of {tlast, tdata} beats.
// Extra pointer MSB separates full from empty.
module axis_sync_fifo
  import usb_pkt_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axis_usb_packetizer_if.slave    wr,
  axis_usb_packetizer_if.master   rd,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [BEAT_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic [AW:0]       wptr_d;
  logic [AW:0]       rptr_d;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;

  assign level_o = wptr_q - rptr_q;
  assign full    = level_o[AW];
  assign empty   = (level_o == '0);

  assign wr.tready = !full;
  assign rd.tvalid = !empty;
  assign {rd.tlast, rd.tdata} = mem_q[rptr_q[AW-1:0]];

  assign wr_en  = wr.tvalid && !full;
  assign rd_en  = rd.tready && !empty;
  assign wptr_d = wptr_q + {{AW{1'b0}}, wr_en};
  assign rptr_d = rptr_q + {{AW{1'b0}}, rd_en};

  // Storage array, written on every accepted beat
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= {wr.tlast, wr.tdata};
    end
  end

  // Read and write pointers, wrapping through the extra MSB
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/axis_usb_packetizer.sv
// Frames a raw byte stream into USB bulk IN packets:
// full packets, early tlast, or an idle-timeout flush.
module axis_usb_packetizer
  import usb_pkt_pkg::*;
#(
  parameter int MAX_PACKET = HS_MAX_PACKET,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         s_axis_tvalid_i,
  output logic                         s_axis_tready_o,
  input  logic                         s_axis_tlast_i,
  input  logic [7:0]                   s_axis_tdata_i,
  output logic                         m_axis_tvalid_o,
  input  logic                         m_axis_tready_i,
  output logic                         m_axis_tlast_o,
  output logic [7:0]                   m_axis_tdata_o,
  output logic [$clog2(FIFO_DEPTH):0]  level_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_PACKET + 1);

  axis_usb_packetizer_if wr_if ();
  axis_usb_packetizer_if rd_if ();

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [RW-1:0] remain_q;
  logic [RW-1:0] len_d;
  logic [LW-1:0] last_cnt_q;
  logic          rdy_q;
  logic          rel_d;
  logic          send;
  logic          wr_fire;
  logic          rd_fire;
  logic          tlast_out;

  assign send = (state_q == SEND);

  assign wr_if.tvalid = s_axis_tvalid_i && rdy_q;
  assign wr_if.tdata  = s_axis_tdata_i;
  assign wr_if.tlast  = s_axis_tlast_i;
  assign s_axis_tready_o = rdy_q && wr_if.tready;

  assign rd_if.tready = send && m_axis_tready_i;
  assign wr_fire = wr_if.tvalid && wr_if.tready;
  assign rd_fire = rd_if.tvalid && rd_if.tready;

  assign m_axis_tvalid_o = send && rd_if.tvalid;
  assign tlast_out = m_axis_tvalid_o &&
                     ((remain_q == RW'(1)) || rd_if.tlast);
  assign m_axis_tlast_o = tlast_out;
  assign m_axis_tdata_o = m_axis_tvalid_o ? rd_if.tdata : 8'h00;

  axis_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .wr      (wr_if),
    .rd      (rd_if),
    .level_o (level_o)
  );

  // Release decision: full packet, then stored tlast, then timeout
  always_comb begin
    rel_d = 1'b0;
    len_d = '0;
    if (level_o >= LW'(MAX_PACKET)) begin
      rel_d = 1'b1;
      len_d = RW'(MAX_PACKET);
    end else if (last_cnt_q != '0) begin
      rel_d = 1'b1;
      len_d = RW'(level_o);
    end else if (timer_q >= TW'(TIMEOUT) && level_o != '0) begin
      rel_d = 1'b1;
      len_d = RW'(level_o);
    end
  end

  // Input ready stays low until the first edge after reset
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // Number of tlast beats currently held in the FIFO
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_cnt_q <= '0;
    end else begin
      last_cnt_q <= last_cnt_q
                    + LW'(wr_fire && wr_if.tlast)
                    - LW'(rd_fire && rd_if.tlast);
    end
  end

  // Release FSM with idle timer and remaining-beat counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      remain_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rel_d) begin
            state_q  <= SEND;
            remain_q <= len_d;
            timer_q  <= '0;
          end else if (wr_fire || level_o == '0) begin
            timer_q <= '0;
          end else if (timer_q < TW'(TIMEOUT)) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        SEND: begin
          timer_q <= '0;
          if (rd_fire) begin
            remain_q <= remain_q - RW'(1);
            if (tlast_out) begin
              state_q  <= IDLE;
              remain_q <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_usb_packetizer.sv
// Randomized bench for axis_usb_packetizer with a
// stream-framing reference model and per-cycle output compare.
`timescale 1ns/1ps
module tb_axis_usb_packetizer;

  localparam int MAXP  = 512;
  localparam int TMO   = 4096;
  localparam int DEPTH = 1024;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [10:0] level;
  logic        rnd_ready = 1'b0;
  logic        mr_fixed = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  axis_usb_packetizer_if s_if ();
  axis_usb_packetizer_if m_if ();

  axis_usb_packetizer #(
    .MAX_PACKET (MAXP),
    .TIMEOUT    (TMO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_axis_tvalid_i (s_if.tvalid),
    .s_axis_tready_o (s_if.tready),
    .s_axis_tlast_i  (s_if.tlast),
    .s_axis_tdata_i  (s_if.tdata),
    .m_axis_tvalid_o (m_if.tvalid),
    .m_axis_tready_i (m_if.tready),
    .m_axis_tlast_o  (m_if.tlast),
    .m_axis_tdata_o  (m_if.tdata),
    .level_o         (level)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #1;
    m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : mr_fixed;
  end

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference model: bytes of the current tlast-segment wait in
  // pend; a segment closes on tlast or at MAXP bytes, and a
  // timeout request closes it early.
  logic [7:0] pend[$];
  logic [8:0] exp_q[$];
  int         pkt_len[$];
  int         out_cnt = 0;
  int         beats = 0;
  int         flush_req = 0;
  int         flush_done = 0;
  int         last_acc_cyc = 0;
  logic       stall = 1'b0;
  logic [8:0] stall_beat;
  logic [8:0] beat;

  function automatic void flush_pend();
    logic l;
    foreach (pend[i]) begin
      l = (i == pend.size() - 1);
      exp_q.push_back({l, pend[i]});
    end
    pend.delete();
  endfunction

  function automatic int plen(input int i);
    return (i < pkt_len.size()) ? pkt_len[i] : -1;
  endfunction

  always @(negedge aclk) begin
    if (areset) begin
      pend.delete();
      exp_q.delete();
      beats = 0;
      stall = 1'b0;
    end else begin
      if (s_if.tvalid && s_if.tready) begin
        pend.push_back(s_if.tdata);
        last_acc_cyc = cyc;
        if (s_if.tlast || pend.size() == MAXP) flush_pend();
      end
      while (flush_done < flush_req) begin
        flush_pend();
        flush_done++;
      end
      if (stall) begin
        chk("hold_valid", {31'd0, m_if.tvalid}, 1);
        chk("hold_beat", {23'd0, m_if.tlast, m_if.tdata},
            {23'd0, stall_beat});
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %0h expected none",
                   {m_if.tlast, m_if.tdata});
        end else begin
          beat = exp_q.pop_front();
          chk("out_beat", {23'd0, m_if.tlast, m_if.tdata},
              {23'd0, beat});
        end
        out_cnt++;
        beats++;
        if (m_if.tlast) begin
          chk("pkt_len_range", {31'd0, (beats >= 1 && beats <= MAXP)}, 1);
          pkt_len.push_back(beats);
          beats = 0;
        end
      end
      stall = m_if.tvalid && !m_if.tready;
      stall_beat = {m_if.tlast, m_if.tdata};
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = l;
    @(negedge aclk);
    while (!s_if.tready && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no tready expected tready");
    end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int t;
    t = 0;
    @(negedge aclk);
    while ((exp_q.size() != 0 || level != 0 || m_if.tvalid)
           && t < bound) begin
      @(negedge aclk);
      t++;
    end
    chk(nm, {31'd0, (t < bound)}, 1);
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_mvalid"}, {31'd0, m_if.tvalid}, 0);
    chk({nm, "_mlast"}, {31'd0, m_if.tlast}, 0);
    chk({nm, "_mdata"}, {24'd0, m_if.tdata}, 0);
    chk({nm, "_sready"}, {31'd0, s_if.tready}, 0);
    chk({nm, "_level"}, {21'd0, level}, 0);
  endtask

  initial begin
    int base;
    int ob;
    int t;
    int d;
    int len;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tlast  = 1'b0;

    // Reset state and ready rising one cycle after release
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_zero_outputs("reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_held_low", {31'd0, s_if.tready}, 0);
    @(negedge aclk);
    chk("ready_rise", {31'd0, s_if.tready}, 1);
    @(posedge aclk);
    #1;

    // 1536 bytes, no tlast -> 3 x 512
    mr_fixed = 1'b1;
    base = pkt_len.size();
    ob = out_cnt;
    for (int i = 0; i < 1536; i++) send_byte(8'(i), 1'b0);
    wait_drain("drain_1536", 20000);
    chk("s1536_pkts", pkt_len.size() - base, 3);
    chk("s1536_len0", plen(base), 512);
    chk("s1536_len1", plen(base + 1), 512);
    chk("s1536_len2", plen(base + 2), 512);
    chk("s1536_bytes", out_cnt - ob, 1536);

    // 100 bytes then idle -> flushed by timeout
    base = pkt_len.size();
    for (int i = 0; i < 100; i++) send_byte(8'(i * 3 + 7), 1'b0);
    flush_req++;
    t = 0;
    @(negedge aclk);
    while (!m_if.tvalid && t < 6000) begin
      @(negedge aclk);
      t++;
    end
    d = cyc - last_acc_cyc;
    chk("timeout_release_delay", d, 4098);
    wait_drain("drain_timeout", 1000);
    chk("timeout_len", plen(base), 100);
    chk("timeout_level", {21'd0, level}, 0);

    // 700 bytes ending in tlast -> 512 + 188 without timeout
    base = pkt_len.size();
    for (int i = 0; i < 700; i++) send_byte(8'(i ^ 8'h3C), i == 699);
    wait_drain("drain_700_fast", 1000);
    chk("s700_len0", plen(base), 512);
    chk("s700_len1", plen(base + 1), 188);

    // Output stalled: input back-pressured at exactly 1024
    mr_fixed = 1'b0;
    idle(2);
    base = pkt_len.size();
    for (int i = 0; i < 1023; i++) send_byte(8'(i ^ 8'h5A), 1'b0);
    @(negedge aclk);
    chk("bp_ready_1023", {31'd0, s_if.tready}, 1);
    chk("bp_level_1023", {21'd0, level}, 1023);
    @(posedge aclk);
    #1;
    send_byte(8'hA5, 1'b0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hEE;
    s_if.tlast  = 1'b1;
    repeat (20) @(negedge aclk);
    chk("bp_ready_full", {31'd0, s_if.tready}, 0);
    chk("bp_level_full", {21'd0, level}, 1024);
    mr_fixed = 1'b1;
    send_byte(8'hEE, 1'b1);
    wait_drain("drain_bp", 5000);
    chk("bp_len0", plen(base), 512);
    chk("bp_len1", plen(base + 1), 512);
    chk("bp_len2", plen(base + 2), 1);

    // Random output ready with bursty tlast-framed input
    rnd_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      len = $urandom_range(1, 1100);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
        send_byte(8'($urandom), i == len - 1);
      end
      idle($urandom_range(0, 20));
    end
    wait_drain("drain_random", 30000);
    rnd_ready = 1'b0;
    mr_fixed = 1'b1;
    idle(2);

    // Reset in the middle of a 512-byte packet
    ob = out_cnt;
    for (int i = 0; i < 512; i++) send_byte(8'(i + 1), 1'b0);
    t = 0;
    while (out_cnt - ob < 300 && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    chk("mid_reset_reached", {31'd0, (t < 2000)}, 1);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(negedge aclk);
    chk_zero_outputs("mid_reset");
    idle(2);
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_ready_low", {31'd0, s_if.tready}, 0);
    @(posedge aclk);
    #1;
    base = pkt_len.size();
    ob = out_cnt;
    for (int i = 0; i < 512; i++) send_byte(8'(255 - i), 1'b0);
    wait_drain("drain_after_reset", 3000);
    chk("after_reset_pkts", pkt_len.size() - base, 1);
    chk("after_reset_len", plen(base), 512);
    chk("after_reset_bytes", out_cnt - ob, 512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
